// File: rtl/y2151_timer_regs_pkg.sv
// Shared register map, control-bit positions and status layout for the y2151 timer/register block.
// Pure declarations: no logic, no latency.
package y2151_pkg;

   localparam logic [7:0] REG_CLKA1 = 8'h10;
   localparam logic [7:0] REG_CLKA2 = 8'h11;
   localparam logic [7:0] REG_CLKB  = 8'h12;
   localparam logic [7:0] REG_TCTRL = 8'h14;

   localparam int CTL_LOADA   = 0;
   localparam int CTL_LOADB   = 1;
   localparam int CTL_IRQENA  = 2;
   localparam int CTL_IRQENB  = 3;
   localparam int CTL_FRESETA = 4;
   localparam int CTL_FRESETB = 5;
   localparam int CTL_CSM     = 7;

   // Flag-reset bits are strobes and never stick in the control register.
   localparam logic [7:0] CTL_STROBE_MASK = 8'h30;

   typedef struct packed {
      logic       busy;
      logic [4:0] rsvd;
      logic       flag_b;
      logic       flag_a;
   } status_t;

endpackage

// File: rtl/y2151_timer_regs_if.sv
// Host CPU bus of the y2151 register block: address/data port select, strobes and read data.
// Purely structural; the slave registers Dout one cycle after a read strobe.
interface y2151_timer_regs_if;
   logic [7:0] Din;
   logic [7:0] Dout;
   logic       A0;
   logic       WR_b;
   logic       RD_b;
   logic       CS_b;

   modport master (output Din, A0, WR_b, RD_b, CS_b, input Dout);
   modport slave  (input Din, A0, WR_b, RD_b, CS_b, output Dout);
endinterface

// File: rtl/y2151_timer_regs_timer.sv
// Up-counting timer with prescaler: reloads from period on a load rising edge and on overflow.
// ovf is combinational in the cycle before the overflowing edge; holds its count while load is low.
module y2151_timer #(
   parameter int CNT_W    = 10,
   parameter int PRESCALE = 64
) (
   input  logic             phiM,
   input  logic             IC,
   input  logic [CNT_W-1:0] period,
   input  logic             load,
   output logic             ovf
);

   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   typedef enum logic {ST_STOPPED, ST_RUNNING} state_t;

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;

   assign tick = (pre_q == PRE_LAST);

   // load is the control bit as it will be after this edge, so a 0->1 write restarts here.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cnt_d   = cnt_q;
      ovf     = 1'b0;
      case (state_q)
         ST_STOPPED: begin
            if (load) begin
               state_d = ST_RUNNING;
               cnt_d   = period;
               pre_d   = '0;
            end
         end
         ST_RUNNING: begin
            if (!load) begin
               state_d = ST_STOPPED;
            end else begin
               pre_d = tick ? '0 : pre_q + PRE_W'(1);
               if (tick) begin
                  if (&cnt_q) begin
                     cnt_d = period;
                     ovf   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         default: state_d = ST_STOPPED;
      endcase
   end

   always_ff @(posedge phiM) begin
      if (IC) begin
         state_q <= ST_STOPPED;
         pre_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/y2151_timer_regs.sv
// y2151 host register file with timers A/B, overflow flags, busy flag, IRQ and CSM strobe.
// Dout/flags/iRQ_b/csm_pulse are registered; the host bus has no backpressure (busy is advisory).
module y2151_timer_regs
   import y2151_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int TA_PRESCALE = 64,
   parameter int TB_PRESCALE = 1024,
   parameter int BUSY_CYCLES = 64
) (
   input  logic                phiM,
   input  logic                IC,
   y2151_timer_regs_if.slave   bus,
   output logic                iRQ_b,
   output logic                csm_pulse,
   input  logic [ADDR_W-1:0]   eng_addr,
   output logic [7:0]          eng_data
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam int BUSY_W   = $clog2(BUSY_CYCLES + 1);

   localparam logic [ADDR_W-1:0] A_CLKA1 = ADDR_W'(REG_CLKA1);
   localparam logic [ADDR_W-1:0] A_CLKA2 = ADDR_W'(REG_CLKA2);
   localparam logic [ADDR_W-1:0] A_CLKB  = ADDR_W'(REG_CLKB);
   localparam logic [ADDR_W-1:0] A_TCTRL = ADDR_W'(REG_TCTRL);

   logic [7:0]        regs_q [NUM_REGS];
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BUSY_W-1:0] busy_q, busy_d;
   logic              flag_a_q, flag_a_d;
   logic              flag_b_q, flag_b_d;
   logic [7:0]        dout_q, dout_d;
   logic              irq_b_q, irq_b_d;
   logic              csm_q, csm_d;

   logic              host_wr, host_rd, addr_wr, data_wr, ctrl_wr;
   logic [7:0]        wr_dat;
   logic              load_a, load_b, ovf_a, ovf_b;
   logic [9:0]        period_a;
   logic [7:0]        period_b;
   status_t           status;

   assign period_a = {regs_q[A_CLKA1], regs_q[A_CLKA2][1:0]};
   assign period_b = regs_q[A_CLKB];
   assign eng_data = regs_q[eng_addr];

   always_comb begin
      host_wr = ~bus.CS_b & ~bus.WR_b;
      host_rd = ~bus.CS_b & ~bus.RD_b;
      addr_wr = host_wr & ~bus.A0;
      data_wr = host_wr & bus.A0;
      ctrl_wr = data_wr & (addr_q == A_TCTRL);
      wr_dat  = ctrl_wr ? (bus.Din & ~CTL_STROBE_MASK) : bus.Din;
      load_a  = ctrl_wr ? bus.Din[CTL_LOADA] : regs_q[A_TCTRL][CTL_LOADA];
      load_b  = ctrl_wr ? bus.Din[CTL_LOADB] : regs_q[A_TCTRL][CTL_LOADB];

      addr_d = addr_wr ? ADDR_W'(bus.Din) : addr_q;

      busy_d = busy_q;
      if (data_wr) begin
         busy_d = BUSY_W'(BUSY_CYCLES);
      end else if (busy_q != '0) begin
         busy_d = busy_q - BUSY_W'(1);
      end

      // An overflow landing on the same edge as a flag-reset strobe keeps the flag set.
      flag_a_d = flag_a_q;
      if (ovf_a && regs_q[A_TCTRL][CTL_IRQENA]) begin
         flag_a_d = 1'b1;
      end else if (ctrl_wr && bus.Din[CTL_FRESETA]) begin
         flag_a_d = 1'b0;
      end

      flag_b_d = flag_b_q;
      if (ovf_b && regs_q[A_TCTRL][CTL_IRQENB]) begin
         flag_b_d = 1'b1;
      end else if (ctrl_wr && bus.Din[CTL_FRESETB]) begin
         flag_b_d = 1'b0;
      end

      status.busy   = (busy_q != '0);
      status.rsvd   = '0;
      status.flag_b = flag_b_q;
      status.flag_a = flag_a_q;
      dout_d        = host_rd ? status : 8'h00;

      irq_b_d = ~(flag_a_q | flag_b_q);
      csm_d   = ovf_a & regs_q[A_TCTRL][CTL_CSM];
   end

   always_ff @(posedge phiM) begin
      if (IC) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         addr_q   <= '0;
         busy_q   <= '0;
         flag_a_q <= 1'b0;
         flag_b_q <= 1'b0;
         dout_q   <= 8'h00;
         irq_b_q  <= 1'b1;
         csm_q    <= 1'b0;
      end else begin
         if (data_wr) begin
            regs_q[addr_q] <= wr_dat;
         end
         addr_q   <= addr_d;
         busy_q   <= busy_d;
         flag_a_q <= flag_a_d;
         flag_b_q <= flag_b_d;
         dout_q   <= dout_d;
         irq_b_q  <= irq_b_d;
         csm_q    <= csm_d;
      end
   end

   assign bus.Dout  = dout_q;
   assign iRQ_b     = irq_b_q;
   assign csm_pulse = csm_q;

   y2151_timer #(
      .CNT_W    (10),
      .PRESCALE (TA_PRESCALE)
   ) u_timer_a (
      .phiM   (phiM),
      .IC     (IC),
      .period (period_a),
      .load   (load_a),
      .ovf    (ovf_a)
   );

   y2151_timer #(
      .CNT_W    (8),
      .PRESCALE (TB_PRESCALE)
   ) u_timer_b (
      .phiM   (phiM),
      .IC     (IC),
      .period (period_b),
      .load   (load_b),
      .ovf    (ovf_b)
   );

endmodule

// File: doc/y2151_timer_regs.md
Name: y2151_timer_regs

Overview:
- Parametrised successor of the y2151 register-file stub: host-bus register file plus a functional status path.
- Adds timers A/B, overflow flags, a busy flag, IRQ generation, the CSM pulse and a second read port for the future sound engine.
- Sits between the CPU bus decode and the (future) operator/envelope engine; produces no audio.

Parameters:
- ADDR_W, 8, register address width; NUM_REGS = 2**ADDR_W.
- TA_PRESCALE, 64, phiM cycles per timer-A tick.
- TB_PRESCALE, 1024, phiM cycles per timer-B tick.
- BUSY_CYCLES, 64, phiM cycles the busy flag stays set after a data write.

Ports:
- phiM  in  1  master clock; all logic on posedge.
- IC  in  1  initial clear; synchronous, active-high.
- Din  in  8  host write data.
- Dout  out  8  host read data, registered.
- A0  in  1  0 = address port, 1 = data port.
- WR_b  in  1  write strobe, active-low.
- RD_b  in  1  read strobe, active-low.
- CS_b  in  1  chip select, active-low.
- iRQ_b  out  1  interrupt request, active-low.
- csm_pulse  out  1  one-cycle strobe on timer-A overflow when CSM is enabled.
- eng_addr  in  ADDR_W  engine read address.
- eng_data  out  8  combinational regs[eng_addr].

Behaviour:
- Reset (IC=1 at posedge):
  - All regs, addr latch, timer counters, prescalers, flags and busy counter are cleared.
  - Dout=0, iRQ_b=1, csm_pulse=0.
- Host write (~CS_b & ~WR_b, sampled each cycle; a strobe held N cycles counts as N writes):
  - A0=0: addr <= Din.
  - A0=1: regs[addr] <= Din, then busy counter <= BUSY_CYCLES.
  - A write during busy is still accepted and restarts the counter.
- Busy counter decrements to 0 and saturates there. busy = (counter != 0).
- Host read (~CS_b & ~RD_b): next cycle Dout = {busy, 5'b0, flagB, flagA}. Otherwise Dout = 8'h00.
- Timer register map:
  - NA = {regs[0x10], regs[0x11][1:0]} (10 bits).
  - NB = regs[0x12].
  - Control register 0x14: bit0 LOADA, bit1 LOADB, bit2 IRQENA, bit3 IRQENB, bit4 FRESETA, bit5 FRESETB, bit7 CSM.
- Writes to 0x14:
  - Bits 4/5 act as one-cycle clear strobes for flagA/flagB. They are stored as 0.
  - All other bits are stored normally.
- Timer A states (Timer B is identical using NB, an 8-bit counter and TB_PRESCALE):
  - STOPPED: entered whenever LOADA=0. Counter and prescaler hold their values.
  - LOADA 0->1 (same cycle the write lands): cntA <= NA, prescaler <= 0, state RUNNING.
  - RUNNING: the prescaler counts 0..TA_PRESCALE-1; at the wrap, cntA increments.
  - Overflow: when cntA == 1023 and a tick occurs, cntA <= NA (current value, reload) and ovfA is asserted for one cycle.
  - Overflow period is therefore (1024-NA)*TA_PRESCALE cycles after load.
  - Writes to NA while running affect only the next reload.
- Flags:
  - flagA <= 1 on ovfA if IRQENA.
  - flagA cleared by an FRESETA strobe.
  - If overflow and FRESET fall on the same cycle, the set wins.
  - Clearing IRQENA does not clear an already-set flag.
- iRQ_b = ~(flagA | flagB), registered (1-cycle latency after the flag).
- csm_pulse = ovfA & CSM, registered.
- Reset asserted mid-count: everything returns to reset values the next cycle. Timers are stopped until re-armed by a LOAD write.
- eng_data reads current register contents, including a same-cycle write (write-first bypass not required; old data acceptable).

Decomposition:
- Package y2151_pkg holds:
  - Register address constants: REG_CLKA1=8'h10, REG_CLKA2=8'h11, REG_CLKB=8'h12, REG_TCTRL=8'h14.
  - Control-bit index constants.
  - Typedef for the status byte.
- One sub-module, y2151_timer:
  - Parameters CNT_W and PRESCALE.
  - Ports: phiM, IC, period, load, ovf.
  - Instantiated twice (A: CNT_W=10, B: CNT_W=8).

Test Plan (bench overrides TA_PRESCALE=2, TB_PRESCALE=4, BUSY_CYCLES=4):
- Pulse IC after random writes -> regs readable as 0 via eng_data, Dout=0, iRQ_b=1.
- Write addr 0x20, data 0x5A -> eng_data(0x20)=0x5A. Read the status on the following 4 cycles -> bit7=1. After the counter expires -> status 0x00.
- NA=1020 (0x10=0xFF, 0x11=0x00), write 0x14=0x05 -> flagA set and iRQ_b low exactly 4*2 cycles after the load plus the flag/IRQ register latency. Status reads 0x01.
- NB=254, 0x14=0x0A -> flagB after 2*4 cycles. Write 0x14=0x2A -> flagB clears and iRQ_b returns high. The timer keeps running and flagB sets again after 8 more cycles.
- Same cycle overflow + FRESETA -> flagA stays 1. LOADA=1 with IRQENA=0 -> no flag and iRQ_b stays 1.
- 0x14=0x81 with NA=1023 -> csm_pulse high for exactly one cycle every 2 cycles. Setting 0x14=0x00 -> pulses stop.
